// File: rtl/board_io_scan_ctrl_if.sv
// Front-panel signal bundle between the register/switch side
// and the panel scan controller.
interface board_io_scan_ctrl_if #(
  parameter int N_DIGITS = 2,
  parameter int LED_W    = 8
);
  logic                  pause;
  logic [4*N_DIGITS-1:0] hex_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank;
  logic [1:0]            led_mode;
  logic [LED_W-1:0]      led;
  logic [7:0]            digit_seg;
  logic [N_DIGITS-1:0]   digit_cath;
  logic [2:0]            rgb_led1;
  logic [2:0]            rgb_led2;

  modport master (
    output pause, hex_in, dp_in, blank, led_mode,
    input  led, digit_seg, digit_cath, rgb_led1, rgb_led2
  );

  modport slave (
    input  pause, hex_in, dp_in, blank, led_mode,
    output led, digit_seg, digit_cath, rgb_led1, rgb_led2
  );
endinterface

// File: rtl/board_io_scan_ctrl.sv
// Seven-segment scan, LED bar animation and RGB rotation,
// all paced by clock-enable ticks in the clk_50m domain.
module board_io_scan_ctrl #(
  parameter int N_DIGITS = 2,
  parameter int LED_W    = 8,
  parameter int SCAN_DIV = 2048,
  parameter int LED_DIV  = 4194304,
  parameter int RGB_DIV  = 16777216
) (
  input logic             clk_50m,
  input logic             reset,
  board_io_scan_ctrl_if.slave io
);

  function automatic logic [LED_W-1:0] alt_seed();
    logic [LED_W-1:0] p;
    p = '0;
    for (int i = 0; i < LED_W; i++)
      p[i] = ((LED_W - 1 - i) % 2) == 0;
    return p;
  endfunction

  function automatic logic [7:0] hex_seg(
    input logic [3:0] h
  );
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  localparam int SW = $clog2(SCAN_DIV);
  localparam int LW = $clog2(LED_DIV);
  localparam int RW = $clog2(RGB_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [LW-1:0] LED_MAX  = LW'(LED_DIV - 1);
  localparam logic [RW-1:0] RGB_MAX  = RW'(RGB_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);

  localparam logic [LED_W-1:0] ALT_SEED = alt_seed();
  localparam logic [LED_W-1:0] ONE_SEED =
    {{(LED_W-1){1'b0}}, 1'b1};

  logic [SW-1:0] scan_cnt;
  logic [LW-1:0] led_cnt;
  logic [RW-1:0] rgb_cnt;
  logic          scan_tick;
  logic          led_tick;
  logic          rgb_tick;

  assign scan_tick = !io.pause && (scan_cnt == SCAN_MAX);
  assign led_tick  = !io.pause && (led_cnt == LED_MAX);
  assign rgb_tick  = !io.pause && (rgb_cnt == RGB_MAX);

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      scan_cnt <= '0;
      led_cnt  <= '0;
      rgb_cnt  <= '0;
    end else if (!io.pause) begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SW'(1);
      led_cnt  <= led_tick  ? '0 : led_cnt  + LW'(1);
      rgb_cnt  <= rgb_tick  ? '0 : rgb_cnt  + RW'(1);
    end
  end

  logic [IW-1:0]       digit_idx;
  logic [IW-1:0]       idx_nxt;
  logic [3:0]          nib;
  logic [7:0]          seg_full;
  logic [7:0]          seg_nxt;
  logic [7:0]          seg_q;
  logic [N_DIGITS-1:0] cath_q;

  // Outputs are registered from the next index so they never lag it.
  always_comb begin
    idx_nxt = digit_idx;
    if (scan_tick)
      idx_nxt = (digit_idx == IDX_MAX) ? '0 : digit_idx + IW'(1);
    nib      = io.hex_in[4*idx_nxt +: 4];
    seg_full = hex_seg(nib);
    seg_nxt  = {seg_full[7:1], io.dp_in[idx_nxt]};
    if (io.blank[idx_nxt])
      seg_nxt = '0;
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      digit_idx <= '0;
      cath_q    <= ~{{(N_DIGITS-1){1'b0}}, 1'b1};
      seg_q     <= '0;
    end else begin
      digit_idx <= idx_nxt;
      cath_q    <= ~(N_DIGITS'(1) << idx_nxt);
      seg_q     <= seg_nxt;
    end
  end

  logic [1:0]       mode_q;
  logic             dir_up;
  logic [LED_W-1:0] led_q;

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      mode_q <= 2'b00;
      dir_up <= 1'b1;
      led_q  <= ALT_SEED;
    end else begin
      mode_q <= io.led_mode;
      if (io.led_mode != mode_q) begin
        unique case (io.led_mode)
          2'b00: led_q <= ALT_SEED;
          2'b01, 2'b10: begin
            led_q  <= ONE_SEED;
            dir_up <= 1'b1;
          end
          default: ;
        endcase
      end else if (led_tick) begin
        unique case (mode_q)
          2'b00: led_q <= ~led_q;
          2'b01: led_q <= {led_q[LED_W-2:0], led_q[LED_W-1]};
          2'b10: begin
            // Direction flips on the end bit within the same step.
            if (dir_up) begin
              if (led_q[LED_W-1]) begin
                led_q  <= led_q >> 1;
                dir_up <= 1'b0;
              end else begin
                led_q <= led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_q  <= led_q << 1;
                dir_up <= 1'b1;
              end else begin
                led_q <= led_q >> 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [2:0] rgb1_q;
  logic [2:0] rgb2_q;

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      rgb1_q <= 3'b110;
      rgb2_q <= 3'b011;
    end else if (rgb_tick) begin
      rgb1_q <= {rgb1_q[1:0], rgb1_q[2]};
      rgb2_q <= {rgb2_q[1:0], rgb2_q[2]};
    end
  end

  assign io.led        = led_q;
  assign io.digit_seg  = seg_q;
  assign io.digit_cath = cath_q;
  assign io.rgb_led1   = rgb1_q;
  assign io.rgb_led2   = rgb2_q;

endmodule

// File: tb/tb_board_io_scan_ctrl.sv
// Scoreboard bench for board_io_scan_ctrl with short dividers.
// Expected outputs are queued per edge and popped on the next negedge.
module tb_board_io_scan_ctrl;

  localparam int ND = 4;
  localparam int LW = 8;

  logic clk_50m = 1'b0;
  logic reset;

  always #5 clk_50m = ~clk_50m;

  board_io_scan_ctrl_if #(.N_DIGITS(ND), .LED_W(LW)) bif ();

  board_io_scan_ctrl #(
    .N_DIGITS(ND),
    .LED_W   (LW),
    .SCAN_DIV(4),
    .LED_DIV (8),
    .RGB_DIV (16)
  ) dut (
    .clk_50m(clk_50m),
    .reset  (reset),
    .io     (bif)
  );

  typedef struct packed {
    logic [3:0] cath;
    logic [7:0] seg;
    logic [7:0] led;
    logic [2:0] rgb1;
    logic [2:0] rgb2;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [7:0] seg_tbl [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  int         ks;
  logic [1:0] mode_m;
  logic [7:0] led_tbl[$];
  int         led_pos;
  bit         hold;
  logic [7:0] cur_led;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s@%0d: got %0h want %0h",
               tag, edge_n, got, want);
    end
  endtask

  task automatic load_tbl(input logic [1:0] m);
    case (m)
      2'b00: led_tbl = '{8'hAA, 8'h55};
      2'b01: led_tbl = '{8'h01, 8'h02, 8'h04, 8'h08,
                         8'h10, 8'h20, 8'h40, 8'h80};
      default: led_tbl = '{8'h01, 8'h02, 8'h04, 8'h08,
                           8'h10, 8'h20, 8'h40, 8'h80,
                           8'h40, 8'h20, 8'h10, 8'h08,
                           8'h04, 8'h02};
    endcase
  endtask

  task automatic step();
    obs_t       e;
    obs_t       w;
    obs_t       g;
    int         idx;
    int         r;
    logic [3:0] nib;
    logic [7:0] s;
    if (reset) begin
      ks      = 0;
      mode_m  = 2'b00;
      load_tbl(2'b00);
      led_pos = 0;
      hold    = 0;
      cur_led = led_tbl[0];
    end else begin
      if (!bif.pause) ks++;
      if (bif.led_mode != mode_m) begin
        if (bif.led_mode == 2'b11) begin
          hold = 1;
        end else begin
          hold    = 0;
          load_tbl(bif.led_mode);
          led_pos = 0;
          cur_led = led_tbl[0];
        end
      end else if (!bif.pause && ks % 8 == 0 && !hold) begin
        led_pos = (led_pos + 1) % led_tbl.size();
        cur_led = led_tbl[led_pos];
      end
      mode_m = bif.led_mode;
    end
    idx    = (ks / 4) % ND;
    e.cath = ~(4'(1) << idx);
    if (reset) begin
      e.seg = 8'h00;
    end else begin
      nib   = bif.hex_in[4*idx +: 4];
      s     = seg_tbl[nib];
      e.seg = bif.blank[idx] ? 8'h00 : {s[7:1], bif.dp_in[idx]};
    end
    e.led = cur_led;
    r     = (ks / 16) % 3;
    e.rgb1 = (r == 0) ? 3'b110 : (r == 1) ? 3'b101 : 3'b011;
    e.rgb2 = (r == 0) ? 3'b011 : (r == 1) ? 3'b110 : 3'b101;
    exp_q.push_back(e);
    @(negedge clk_50m);
    edge_n++;
    g.cath = bif.digit_cath;
    g.seg  = bif.digit_seg;
    g.led  = bif.led;
    g.rgb1 = bif.rgb_led1;
    g.rgb2 = bif.rgb_led2;
    w = exp_q.pop_front();
    check("cath", 32'(g.cath), 32'(w.cath));
    check("seg",  32'(g.seg),  32'(w.seg));
    check("led",  32'(g.led),  32'(w.led));
    check("rgb1", 32'(g.rgb1), 32'(w.rgb1));
    check("rgb2", 32'(g.rgb2), 32'(w.rgb2));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset        = 1'b1;
    bif.pause    = 1'b0;
    bif.hex_in   = 16'h3A01;
    bif.dp_in    = '0;
    bif.blank    = '0;
    bif.led_mode = 2'b00;
    repeat (2) @(negedge clk_50m);
    run(2);

    reset = 1'b0;
    run(40);

    bif.blank = 4'b0100;
    bif.dp_in = 4'b0001;
    run(16);
    bif.blank = '0;
    bif.dp_in = '0;
    run(2);

    bif.pause = 1'b1;
    run(20);
    bif.pause = 1'b0;
    run(10);

    bif.hex_in   = 16'($urandom);
    bif.dp_in    = 4'($urandom);
    bif.led_mode = 2'b01;
    run(76);

    bif.led_mode = 2'b10;
    run(128);

    bif.led_mode = 2'b11;
    run(24);

    bif.led_mode = 2'b00;
    run(20);

    run(5);
    bif.pause    = 1'b1;
    reset        = 1'b1;
    run(1);
    reset        = 1'b0;
    bif.pause    = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
